// File: rtl/mul_unfold_hs.sv
// Handshaked shift-add multiplier that retires J multiplier bits per clock.
// Define MUL_SIGNED_EN for two's-complement operands and product.
module mul_unfold_hs #(
    parameter int WIDTH = 8,
    parameter int J     = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int ITER = (WIDTH + J - 1) / J;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
`ifdef MUL_SIGNED_EN
    // Slot of the sign bit of b within the final group
    localparam int KLAST = WIDTH - 1 - (ITER - 1) * J;
`endif

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [2*WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]     b_sh;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   pp;
    logic [CW-1:0]        idx;
    logic [2*WIDTH-1:0]   a_ext;
    logic                 last;
    logic                 accept;

    assign last   = (idx == CW'(ITER - 1));
    assign accept = in_valid && in_ready && !clr;

`ifdef MUL_SIGNED_EN
    assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
`else
    assign a_ext = {{WIDTH{1'b0}}, a};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (in_valid) state_nxt = BUSY;
                BUSY: if (last) state_nxt = DONE;
                DONE: begin
                    if (out_ready) begin
                        state_nxt = in_valid ? BUSY : IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
        out_valid = (state == DONE);
        busy      = (state == BUSY);
    end

    // Operands are pre-shifted each cycle, so group bits always sit at 0..J-1
    always_comb begin
        pp = '0;
        for (int k = 0; k < J; k++) begin
            if (b_sh[k]) begin
`ifdef MUL_SIGNED_EN
                if (last && (k == KLAST)) begin
                    pp = pp - (a_sh << k);
                end else begin
                    pp = pp + (a_sh << k);
                end
`else
                pp = pp + (a_sh << k);
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
            idx  <= '0;
        end else if (clr) begin
            acc <= '0;
            idx <= '0;
        end else if (accept) begin
            a_sh <= a_ext;
            b_sh <= b;
            acc  <= '0;
            idx  <= '0;
        end else if (state == BUSY) begin
            acc  <= acc + pp;
            a_sh <= a_sh << J;
            b_sh <= b_sh >> J;
            idx  <= idx + 1'b1;
        end
    end

    assign product = acc;

endmodule

// File: tb/tb_mul_unfold_hs.sv
// Randomised bench for mul_unfold_hs over several WIDTH/J builds.
// Build with MUL_SIGNED_EN defined to exercise the two's-complement mode.
module tb_mul_unfold_hs;

    localparam int N = 5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid_v  [N];
    logic        out_ready_v [N];
    logic        clr_v       [N];
    logic [7:0]  a_v         [N];
    logic [7:0]  b_v         [N];
    logic        in_ready_v  [N];
    logic        out_valid_v [N];
    logic        busy_v      [N];
    logic [15:0] prod_v      [N];
    logic [15:0] p0, p2, p3, p4;
    logic [9:0]  p1;

    int w_of [N] = '{8, 5, 8, 8, 8};
    int j_of [N] = '{4, 4, 1, 3, 8};

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always_comb begin
        prod_v[0] = p0;
        prod_v[1] = {6'd0, p1};
        prod_v[2] = p2;
        prod_v[3] = p3;
        prod_v[4] = p4;
    end

    mul_unfold_hs #(.WIDTH(8), .J(4)) u0 (
        .clk(clk), .reset_n(reset_n), .clr(clr_v[0]),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_v[0]), .b(b_v[0]), .out_valid(out_valid_v[0]),
        .out_ready(out_ready_v[0]), .product(p0), .busy(busy_v[0])
    );

    mul_unfold_hs #(.WIDTH(5), .J(4)) u1 (
        .clk(clk), .reset_n(reset_n), .clr(clr_v[1]),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_v[1][4:0]), .b(b_v[1][4:0]), .out_valid(out_valid_v[1]),
        .out_ready(out_ready_v[1]), .product(p1), .busy(busy_v[1])
    );

    mul_unfold_hs #(.WIDTH(8), .J(1)) u2 (
        .clk(clk), .reset_n(reset_n), .clr(clr_v[2]),
        .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a_v[2]), .b(b_v[2]), .out_valid(out_valid_v[2]),
        .out_ready(out_ready_v[2]), .product(p2), .busy(busy_v[2])
    );

    mul_unfold_hs #(.WIDTH(8), .J(3)) u3 (
        .clk(clk), .reset_n(reset_n), .clr(clr_v[3]),
        .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
        .a(a_v[3]), .b(b_v[3]), .out_valid(out_valid_v[3]),
        .out_ready(out_ready_v[3]), .product(p3), .busy(busy_v[3])
    );

    mul_unfold_hs #(.WIDTH(8), .J(8)) u4 (
        .clk(clk), .reset_n(reset_n), .clr(clr_v[4]),
        .in_valid(in_valid_v[4]), .in_ready(in_ready_v[4]),
        .a(a_v[4]), .b(b_v[4]), .out_valid(out_valid_v[4]),
        .out_ready(out_ready_v[4]), .product(p4), .busy(busy_v[4])
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference product: plain integer multiply, wrapped to 2*w bits
    function automatic logic [63:0] ref_mul(input int w, input logic [7:0] x,
                                            input logic [7:0] y);
        longint sx, sy, m;
        sx = longint'(x) & ((64'sd1 <<< w) - 1);
        sy = longint'(y) & ((64'sd1 <<< w) - 1);
`ifdef MUL_SIGNED_EN
        if (sx >= (64'sd1 <<< (w - 1))) sx = sx - (64'sd1 <<< w);
        if (sy >= (64'sd1 <<< (w - 1))) sy = sy - (64'sd1 <<< w);
`endif
        m = (sx * sy) & ((64'sd1 <<< (2 * w)) - 1);
        return 64'(m);
    endfunction

    function automatic int iter_of(input int n);
        return (w_of[n] + j_of[n] - 1) / j_of[n];
    endfunction

    // Called #1 after a rising edge with instance n idle
    task automatic do_op(input int n, input logic [7:0] av,
                         input logic [7:0] bv, input bit rel,
                         output logic [15:0] got);
        int lat;
        logic [63:0] exp;
        exp = ref_mul(w_of[n], av, bv);
        a_v[n] = av;
        b_v[n] = bv;
        in_valid_v[n] = 1'b1;
        #1;
        check("in_ready_idle", 64'(in_ready_v[n]), 64'd1);
        @(posedge clk);
        #1;
        in_valid_v[n] = 1'b0;
        a_v[n] = 8'($urandom);
        b_v[n] = 8'($urandom);
        lat = 0;
        while (!out_valid_v[n] && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(iter_of(n)));
        check("product", 64'(prod_v[n]), exp);
        got = prod_v[n];
        if (rel) begin
            out_ready_v[n] = 1'b1;
            @(posedge clk);
            #1;
            out_ready_v[n] = 1'b0;
        end
    endtask

    initial begin
        logic [15:0] got;
        int lat;
        bit seen;
        for (int i = 0; i < N; i++) begin
            in_valid_v[i]  = 1'b0;
            out_ready_v[i] = 1'b0;
            clr_v[i]       = 1'b0;
            a_v[i]         = 8'd0;
            b_v[i]         = 8'd0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_product", 64'(prod_v[0]), 64'd0);
        check("rst_out_valid", 64'(out_valid_v[0]), 64'd0);
        check("rst_busy", 64'(busy_v[0]), 64'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready_v[0]), 64'd1);

        // Directed W=8 J=4 and W=5 J=4
        do_op(0, 8'hFF, 8'hFF, 1'b1, got);
`ifndef MUL_SIGNED_EN
        check("ff_x_ff", 64'(got), 64'hFE01);
`endif
        do_op(0, 8'h00, 8'hA5, 1'b1, got);
        check("zero_x_a5", 64'(got), 64'd0);
        do_op(1, 8'd31, 8'd31, 1'b1, got);
`ifndef MUL_SIGNED_EN
        check("w5_31x31", 64'(got), 64'd961);
`endif
        do_op(1, 8'd13, 8'd17, 1'b1, got);
`ifndef MUL_SIGNED_EN
        check("w5_13x17", 64'(got), 64'd221);
`endif
`ifdef MUL_SIGNED_EN
        do_op(0, 8'h80, 8'h80, 1'b1, got);
        check("s_m128sq", 64'(got), 64'h4000);
        do_op(0, 8'hFF, 8'h01, 1'b1, got);
        check("s_m1x1", 64'(got), 64'hFFFF);
        do_op(0, 8'h7F, 8'hFE, 1'b1, got);
        check("s_127xm2", 64'(got), 64'hFF02);
`endif

        // Back-pressure then back-to-back accept
        do_op(0, 8'hFF, 8'hFF, 1'b0, got);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("bp_valid", 64'(out_valid_v[0]), 64'd1);
            check("bp_hold", 64'(prod_v[0]), ref_mul(8, 8'hFF, 8'hFF));
            check("bp_in_ready", 64'(in_ready_v[0]), 64'd0);
        end
        out_ready_v[0] = 1'b1;
        in_valid_v[0]  = 1'b1;
        a_v[0] = 8'd3;
        b_v[0] = 8'd5;
        #1;
        check("b2b_in_ready", 64'(in_ready_v[0]), 64'd1);
        @(posedge clk);
        #1;
        out_ready_v[0] = 1'b0;
        in_valid_v[0]  = 1'b0;
        check("b2b_busy", 64'(busy_v[0]), 64'd1);
        check("b2b_in_ready_busy", 64'(in_ready_v[0]), 64'd0);
        lat = 0;
        while (!out_valid_v[0] && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b2b_latency", 64'(lat), 64'd2);
        check("b2b_product", 64'(prod_v[0]), 64'd15);
        out_ready_v[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_v[0] = 1'b0;

        // Abort in first busy cycle
        in_valid_v[0] = 1'b1;
        a_v[0] = 8'hC3;
        b_v[0] = 8'h7E;
        @(posedge clk);
        #1;
        in_valid_v[0] = 1'b0;
        check("clr_busy_before", 64'(busy_v[0]), 64'd1);
        clr_v[0] = 1'b1;
        @(posedge clk);
        #1;
        clr_v[0] = 1'b0;
        check("clr_idle", 64'(in_ready_v[0]), 64'd1);
        check("clr_product", 64'(prod_v[0]), 64'd0);
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid_v[0];
        end
        check("clr_no_valid", 64'(seen), 64'd0);

        // clr together with in_valid in IDLE must not accept
        clr_v[0] = 1'b1;
        in_valid_v[0] = 1'b1;
        @(posedge clk);
        #1;
        clr_v[0] = 1'b0;
        in_valid_v[0] = 1'b0;
        check("clr_blocks_accept", 64'(busy_v[0]), 64'd0);

        // Asynchronous reset mid-busy
        in_valid_v[0] = 1'b1;
        a_v[0] = 8'hFF;
        b_v[0] = 8'hFF;
        @(posedge clk);
        #1;
        in_valid_v[0] = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy_v[0]), 64'd0);
        check("arst_valid", 64'(out_valid_v[0]), 64'd0);
        check("arst_product", 64'(prod_v[0]), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_in_ready", 64'(in_ready_v[0]), 64'd1);

        // Random sweeps
        for (int n = 1; n < N; n++) begin
            for (int i = 0; i < ((n == 1) ? 200 : 1000); i++) begin
                do_op(n, 8'($urandom), 8'($urandom), 1'b1, got);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
